mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_req_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters one shared single-port memory.
// Each transaction runs IDLE -> BUSY -> GAP, and every output comes straight from a register.
module mem_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          rq_valid_i,
    input  logic [NUM_REQ-1:0]          rq_rnw_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   rq_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   rq_wdata_i,
    output logic [NUM_REQ-1:0]          rq_ack_o,
    output logic                        rq_err_o,
    output logic [DATA_W-1:0]           rq_rdata_o,
    output logic [NUM_REQ-1:0]          grant_o,
    output logic                        mem_req_o,
    output logic                        mem_rnw_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_wdata_o,
    input  logic                        mem_ready_i,
    input  logic [DATA_W-1:0]           mem_rdata_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   last_grant, last_grant_n;
    logic [IDX_W-1:0]   pick, cand;
    logic               found;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               expired;

    logic               mem_req_n, mem_rnw_n, err_n;
    logic [ADDR_W-1:0]  mem_addr_n;
    logic [DATA_W-1:0]  mem_wdata_n, rdata_n;
    logic [NUM_REQ-1:0] grant_n, ack_n;

    assign expired = (cnt == CNT_W'(TIMEOUT));

    // Search starts one past the previous winner, so a held request cannot starve the others.
    always_comb begin : rr_search
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && rq_valid_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state       <= IDLE;
            last_grant  <= IDX_W'(NUM_REQ - 1);
            cnt         <= '0;
            mem_req_o   <= 1'b0;
            mem_rnw_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            grant_o     <= '0;
            rq_ack_o    <= '0;
            rq_err_o    <= 1'b0;
            rq_rdata_o  <= '0;
        end else begin
            state       <= state_n;
            last_grant  <= last_grant_n;
            cnt         <= cnt_n;
            mem_req_o   <= mem_req_n;
            mem_rnw_o   <= mem_rnw_n;
            mem_addr_o  <= mem_addr_n;
            mem_wdata_o <= mem_wdata_n;
            grant_o     <= grant_n;
            rq_ack_o    <= ack_n;
            rq_err_o    <= err_n;
            rq_rdata_o  <= rdata_n;
        end
    end

    always_comb begin : next_state
        state_n = state;
        case (state)
            IDLE:    if (found) state_n = BUSY;
            BUSY:    if (mem_ready_i || expired) state_n = GAP;
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin : next_outputs
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        last_grant_n = last_grant;
        cnt_n        = cnt;
        mem_req_n    = mem_req_o;
        mem_rnw_n    = mem_rnw_o;
        mem_addr_n   = mem_addr_o;
        mem_wdata_n  = mem_wdata_o;
        grant_n      = grant_o;
        ack_n        = '0;
        err_n        = 1'b0;
        rdata_n      = rq_rdata_o;
        case (state)
            IDLE: begin
                if (found) begin
                    last_grant_n = pick;
                    cnt_n        = CNT_W'(1);
                    mem_req_n    = 1'b1;
                    mem_rnw_n    = rq_rnw_i[pick];
                    mem_addr_n   = rq_addr_i[int'(pick)*ADDR_W +: ADDR_W];
                    mem_wdata_n  = rq_wdata_i[int'(pick)*DATA_W +: DATA_W];
                    grant_n      = '0;
                    grant_n[pick] = 1'b1;
                end
            end
            BUSY: begin
                // A real ready wins over a timeout that expires in the same cycle.
                if (mem_ready_i || expired) begin
                    mem_req_n = 1'b0;
                    grant_n   = '0;
                    ack_n     = grant_o;
                    err_n     = !mem_ready_i;
                    rdata_n   = mem_ready_i ? mem_rdata_i : '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: a table of single transactions plus hand-written
// contention, timeout, withdrawn-request and reset-mid-BUSY sequences, checked by an ack scoreboard.
module tb_mem_req_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_REQ-1:0]        rq_valid_i = '0;
    logic [NUM_REQ-1:0]        rq_rnw_i = '0;
    logic [NUM_REQ*ADDR_W-1:0] rq_addr_i = '0;
    logic [NUM_REQ*DATA_W-1:0] rq_wdata_i = '0;
    logic [NUM_REQ-1:0]        rq_ack_o;
    logic                      rq_err_o;
    logic [DATA_W-1:0]         rq_rdata_o;
    logic [NUM_REQ-1:0]        grant_o;
    logic                      mem_req_o, mem_rnw_o;
    logic [ADDR_W-1:0]         mem_addr_o;
    logic [DATA_W-1:0]         mem_wdata_o;
    logic                      mem_ready_i;
    logic [DATA_W-1:0]         mem_rdata_i;

    mem_req_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .rq_valid_i(rq_valid_i), .rq_rnw_i(rq_rnw_i), .rq_addr_i(rq_addr_i), .rq_wdata_i(rq_wdata_i),
        .rq_ack_o(rq_ack_o), .rq_err_o(rq_err_o), .rq_rdata_o(rq_rdata_o), .grant_o(grant_o),
        .mem_req_o(mem_req_o), .mem_rnw_o(mem_rnw_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Memory model: ready is mem_req_o delayed one cycle, reads are combinational.
    logic [DATA_W-1:0] mem [16];
    logic              ready_q = 1'b0;
    logic              tie_low = 1'b0;
    always @(posedge clk) begin
        ready_q <= mem_req_o;
        if (mem_req_o && !mem_rnw_o) mem[mem_addr_o] <= mem_wdata_o;
    end
    assign mem_ready_i = ready_q & ~tie_low;
    assign mem_rdata_i = mem[mem_addr_o];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [NUM_REQ-1:0] ack;
        logic               err;
        logic [DATA_W-1:0]  rdata;
        bit                 chk;
    } exp_t;

    exp_t sb[$];
    exp_t exp_e;
    int   g1_cnt = 0;

    task automatic expect_ack(input int r, input logic err, input logic [DATA_W-1:0] rd, input bit chk);
        exp_t e;
        e.ack    = '0;
        e.ack[r] = 1'b1;
        e.err    = err;
        e.rdata  = rd;
        e.chk    = chk;
        sb.push_back(e);
    endtask

    // Scoreboard and per-cycle protocol checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            check("grant_vs_mem_req", 64'(grant_o != '0), 64'(mem_req_o));
            if (grant_o[1] || rq_ack_o[1]) g1_cnt++;
            if (rq_ack_o != '0) begin
                check("ack_onehot", 64'($countones(rq_ack_o)), 64'd1);
                if (sb.size() == 0) begin
                    check("unexpected_ack", 64'(rq_ack_o), 64'd0);
                end else begin
                    exp_e = sb.pop_front();
                    check("ack_owner", 64'(rq_ack_o), 64'(exp_e.ack));
                    check("ack_err", 64'(rq_err_o), 64'(exp_e.err));
                    if (exp_e.chk) check("ack_rdata", 64'(rq_rdata_o), 64'(exp_e.rdata));
                end
            end else begin
                check("err_without_ack", 64'(rq_err_o), 64'd0);
            end
        end
    end

    // Low cycles of mem_req_o between transactions; reset abandons the count.
    int   low_run = 100;
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            low_run <= 100;
        end else begin
            if (mem_req_o && !req_prev) check("mem_req_gap_ge2", 64'(low_run >= 2), 64'd1);
            low_run <= mem_req_o ? 0 : low_run + 1;
        end
        req_prev <= mem_req_o;
    end

    task automatic set_req(input int r, input logic rnw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        rq_valid_i[r] = 1'b1;
        rq_rnw_i[r]   = rnw;
        rq_addr_i[r*ADDR_W +: ADDR_W]  = a;
        rq_wdata_i[r*DATA_W +: DATA_W] = d;
    endtask

    // Counts mid-cycle samples from the call point until requester r is acked.
    task automatic wait_ack(input int r, input int exp_lat, input string name);
        int lat;
        bit seen;
        lat  = 0;
        seen = 0;
        for (int i = 1; i <= 64 && !seen; i++) begin
            @(negedge clk);
            if (rq_ack_o[r]) begin
                seen = 1;
                lat  = i;
            end
        end
        if (!seen) check({name, "_ack_timeout"}, 64'd0, 64'd1);
        else       check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    typedef struct {
        int                req;
        logic              rnw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
        bit                chk;
    } vec_t;

    vec_t vecs[8];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
    end

    initial begin
        int ack_t[4];
        int n_ack;

        vecs[0] = '{0, 1'b0, 4'd3,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1] = '{0, 1'b1, 4'd3,  32'h0,        32'hDEADBEEF, 1'b1};
        vecs[2] = '{1, 1'b0, 4'd7,  32'h12345678, 32'h0,        1'b0};
        vecs[3] = '{1, 1'b1, 4'd7,  32'h0,        32'h12345678, 1'b1};
        vecs[4] = '{0, 1'b1, 4'd7,  32'h0,        32'h12345678, 1'b1};
        vecs[5] = '{1, 1'b0, 4'd15, 32'hCAFEF00D, 32'h0,        1'b0};
        vecs[6] = '{0, 1'b1, 4'd15, 32'h0,        32'hCAFEF00D, 1'b1};
        vecs[7] = '{1, 1'b1, 4'd3,  32'h0,        32'hDEADBEEF, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", 64'(mem_req_o), 64'd0);
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_ack", 64'(rq_ack_o), 64'd0);
        check("rst_err", 64'(rq_err_o), 64'd0);
        check("rst_rdata", 64'(rq_rdata_o), 64'd0);
        check("rst_mem_addr", 64'({mem_rnw_o, mem_addr_o, mem_wdata_o}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single transactions: ack must appear in cycle 4 of each
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            set_req(vecs[i].req, vecs[i].rnw, vecs[i].addr, vecs[i].wdata);
            expect_ack(vecs[i].req, 1'b0, vecs[i].exp_rdata, vecs[i].chk);
            wait_ack(vecs[i].req, 4, $sformatf("vec%0d", i));
            @(posedge clk); #1;
            rq_valid_i[vecs[i].req] = 1'b0;
        end

        // Contention from reset: grants alternate 0,1,0,1 with acks 4 cycles apart
        @(posedge clk); #1;
        reset = 1'b1;
        set_req(0, 1'b1, 4'd3, 32'h0);
        set_req(1, 1'b1, 4'd7, 32'h0);
        for (int i = 0; i < 4; i++) expect_ack(i % 2, 1'b0, (i % 2 == 0) ? 32'hDEADBEEF : 32'h12345678, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        n_ack = 0;
        for (int i = 1; i <= 40 && n_ack < 4; i++) begin
            @(negedge clk);
            if (rq_ack_o != '0) begin
                ack_t[n_ack] = i;
                n_ack++;
            end
        end
        check("contention_ack_count", 64'(n_ack), 64'd4);
        if (n_ack == 4) begin
            check("contention_first_ack", 64'(ack_t[0]), 64'd4);
            for (int i = 1; i < 4; i++) check($sformatf("contention_spacing%0d", i), 64'(ack_t[i] - ack_t[i-1]), 64'd4);
        end
        @(posedge clk); #1;
        rq_valid_i = '0;

        // Timeout, then a normal transaction
        @(posedge clk); #1;
        tie_low = 1'b1;
        set_req(0, 1'b1, 4'd3, 32'h0);
        expect_ack(0, 1'b1, 32'h0, 1'b1);
        wait_ack(0, TIMEOUT + 2, "timeout");
        @(posedge clk); #1;
        rq_valid_i[0] = 1'b0;
        tie_low = 1'b0;
        @(posedge clk); #1;
        set_req(1, 1'b1, 4'd3, 32'h0);
        expect_ack(1, 1'b0, 32'hDEADBEEF, 1'b1);
        wait_ack(1, 4, "after_timeout");
        @(posedge clk); #1;
        rq_valid_i[1] = 1'b0;

        // Withdrawn request: req1 pulses for one cycle while req0 is BUSY
        @(posedge clk); #1;
        g1_cnt = 0;
        set_req(0, 1'b1, 4'd7, 32'h0);
        expect_ack(0, 1'b0, 32'h12345678, 1'b1);
        @(posedge clk); #1;
        set_req(1, 1'b1, 4'd3, 32'h0);
        @(posedge clk); #1;
        rq_valid_i[1] = 1'b0;
        wait_ack(0, 2, "withdrawn_req0");
        @(posedge clk); #1;
        rq_valid_i[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("withdrawn_req1_activity", 64'(g1_cnt), 64'd0);

        // Reset in the first BUSY cycle of a req1 transaction
        @(posedge clk); #1;
        set_req(1, 1'b1, 4'd3, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        set_req(0, 1'b1, 4'd15, 32'h0);
        @(negedge clk);
        check("busy1_grant_req1", 64'(grant_o), 64'b10);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("after_rst_mem_req", 64'(mem_req_o), 64'd0);
        check("after_rst_grant", 64'(grant_o), 64'd0);
        check("after_rst_ack", 64'(rq_ack_o), 64'd0);
        expect_ack(0, 1'b0, 32'hCAFEF00D, 1'b1);
        @(negedge clk);
        check("after_rst_first_grant", 64'(grant_o), 64'b01);
        @(posedge clk); #1;
        rq_valid_i[1] = 1'b0;
        wait_ack(0, 2, "after_rst_req0");
        @(posedge clk); #1;
        rq_valid_i[0] = 1'b0;
        repeat (6) @(negedge clk);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
